// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hamming_pkg
// Purpose  : Shared Hamming code geometry: widths and position classification.
// Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

  function automatic int total_width(input int data_width, input int parity_bits);
    return data_width + parity_bits;
  endfunction

  // Parity bits live at positions 1, 2, 4, 8, ...
  function automatic bit is_power_of_two(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Index of a data position within the payload: skip every parity slot at or below it.
  function automatic int data_index(input int pos);
    return pos - 1 - $clog2(pos + 1);
  endfunction

  function automatic int parity_index(input int pos);
    return $clog2(pos);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_splitter.sv
`default_nettype none
// ============================================================================
// Module   : hamming_splitter
// Purpose  : Splits a Hamming codeword into payload and parity fields.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_splitter
  import hamming_pkg::*;
#(
  parameter int PARITY_BITS = 4,
  parameter int DATA_WIDTH  = (1 << PARITY_BITS) - PARITY_BITS - 1,
  localparam int TOTAL_WIDTH = total_width(DATA_WIDTH, PARITY_BITS)
) (
  input  logic [TOTAL_WIDTH-1:0] codeword,
  output logic [DATA_WIDTH-1:0]  data,
  output logic [PARITY_BITS-1:0] parity
);

  for (genvar pos = 1; pos <= TOTAL_WIDTH; pos++) begin : g_pos
    if (is_power_of_two(pos)) begin : g_parity
      assign parity[parity_index(pos)] = codeword[pos-1];
    end else begin : g_data
      assign data[data_index(pos)] = codeword[pos-1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/hamming_corrector.sv
`default_nettype none
// ============================================================================
// Module   : hamming_corrector
// Purpose  : Two-stage single-error-correcting Hamming decoder with
//            valid/ready flow control and a saturating corrected-word counter.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_corrector
  import hamming_pkg::*;
#(
  parameter int PARITY_BITS = 4,
  parameter int DATA_WIDTH  = (1 << PARITY_BITS) - PARITY_BITS - 1,
  parameter int CNT_WIDTH   = 16,
  localparam int TOTAL_WIDTH = total_width(DATA_WIDTH, PARITY_BITS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_WIDTH-1:0] in_codeword,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [PARITY_BITS-1:0] out_syndrome,
  output logic                   out_corrected,
  output logic                   out_parity_err,
  input  logic                   cnt_clear,
  output logic [CNT_WIDTH-1:0]   err_count
);

  logic                   w_advance;
  logic [PARITY_BITS-1:0] w_syndrome;
  logic [TOTAL_WIDTH-1:0] w_fixed;
  logic [DATA_WIDTH-1:0]  w_data;
  logic [PARITY_BITS-1:0] w_parity_unused;
  logic                   w_corr;
  logic                   w_perr;
  logic                   w_count_inc;

  logic                   r_s1_valid;
  logic [TOTAL_WIDTH-1:0] r_s1_code;
  logic [PARITY_BITS-1:0] r_s1_syn;
  logic                   r_s2_valid;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [PARITY_BITS-1:0] r_out_syn;
  logic                   r_out_corr;
  logic                   r_out_perr;
  logic [CNT_WIDTH-1:0]   r_err_count;

  assign w_advance = !r_s2_valid || out_ready;
  assign in_ready  = w_advance;

  // Syndrome bit k covers every position whose index has bit k set.
  always_comb begin
    w_syndrome = '0;
    for (int pos = 1; pos <= TOTAL_WIDTH; pos++) begin
      for (int k = 0; k < PARITY_BITS; k++) begin
        if (pos[k]) w_syndrome[k] = w_syndrome[k] ^ in_codeword[pos-1];
      end
    end
  end

  // A syndrome beyond the codeword length (shortened codes) flips nothing.
  always_comb begin
    w_fixed = r_s1_code;
    for (int pos = 1; pos <= TOTAL_WIDTH; pos++) begin
      if (int'(r_s1_syn) == pos) w_fixed[pos-1] = ~r_s1_code[pos-1];
    end
  end

  assign w_corr = |r_s1_syn;
  assign w_perr = is_power_of_two(int'(r_s1_syn));

  hamming_splitter #(
    .PARITY_BITS (PARITY_BITS),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_splitter (
    .codeword (w_fixed),
    .data     (w_data),
    .parity   (w_parity_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_syn   <= '0;
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_syn  <= '0;
      r_out_corr <= 1'b0;
      r_out_perr <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      r_s1_code  <= in_codeword;
      r_s1_syn   <= w_syndrome;
      r_s2_valid <= r_s1_valid;
      r_out_data <= w_data;
      r_out_syn  <= r_s1_syn;
      r_out_corr <= w_corr;
      r_out_perr <= w_perr;
    end
  end

  assign w_count_inc = r_s2_valid && out_ready && r_out_corr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (cnt_clear) begin
      r_err_count <= '0;
    end else if (w_count_inc && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign out_valid      = r_s2_valid;
  assign out_data       = r_out_data;
  assign out_syndrome   = r_out_syn;
  assign out_corrected  = r_out_corr;
  assign out_parity_err = r_out_perr;
  assign err_count      = r_err_count;

endmodule
`default_nettype wire
